// File: rtl/ahb_err_subordinate_if.sv
// AHB-Lite bus bundle between the interconnect and one subordinate.
// The slave modport is the view taken by the subordinate.
interface ahb_err_subordinate_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic [1:0]            HRESP;
  logic                  HREADYOUT;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HRESP, HREADYOUT
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HRESP, HREADYOUT
  );
endinterface

// File: rtl/ahb_err_subordinate.sv
// AHB-Lite default subordinate: answers unmapped transfers with a two-cycle
// ERROR (or zero-data OKAY) after WAIT_STATES wait cycles, and logs them.
module ahb_err_subordinate #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RESP_MODE   = 0,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_err_subordinate_if.slave  bus,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write
);

  localparam int unsigned WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  if (WAIT_STATES > 15) begin : g_wait_states_check
    $error("ahb_err_subordinate: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ERR1 = 3'd2,
    S_ERR2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam state_t RESP_STATE  = (RESP_MODE != 0) ? S_DONE : S_ERR1;
  localparam state_t ENTRY_STATE = (WAIT_STATES > 0) ? S_WAIT : RESP_STATE;

  state_t                r_state;
  state_t                w_next_state;
  logic [WCNT_W-1:0]     r_wait_cnt;
  logic                  r_hreadyout;
  logic [1:0]            r_hresp;
  logic [CNT_WIDTH-1:0]  r_err_count;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_write;
  logic                  w_accept;
  logic                  w_unused;

  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_unused = ^{bus.HTRANS[0], bus.HSIZE, bus.HBURST, bus.HWDATA};

  // Next state; completing cycles (IDLE/ERR2/DONE) may start a new response.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_ERR2, S_DONE: w_next_state = w_accept ? ENTRY_STATE : S_IDLE;
      S_WAIT:                 if (r_wait_cnt == '0) w_next_state = RESP_STATE;
      S_ERR1:                 w_next_state = S_ERR2;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // State, wait counter and state-decoded response flops.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= RESP_OKAY;
    end else begin
      r_state     <= w_next_state;
      r_hreadyout <= (w_next_state != S_WAIT) && (w_next_state != S_ERR1);
      r_hresp     <= ((w_next_state == S_ERR1) || (w_next_state == S_ERR2)) ?
                     RESP_ERROR : RESP_OKAY;
      if ((w_next_state == S_WAIT) && (r_state != S_WAIT)) begin
        r_wait_cnt <= WAIT_LOAD;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
      end
    end
  end

  // Debug bookkeeping; an accept wins over a clear but restarts the count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
      r_err_write <= 1'b0;
    end else if (w_accept) begin
      if (err_clr) begin
        r_err_count <= CNT_WIDTH'(1);
      end else if (!(&r_err_count)) begin
        r_err_count <= r_err_count + CNT_WIDTH'(1);
      end
      r_err_addr  <= bus.HADDR;
      r_err_write <= bus.HWRITE;
    end else if (err_clr) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
      r_err_write <= 1'b0;
    end
  end

  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRESP     = r_hresp;
  assign bus.HRDATA    = '0;
  assign err_count     = r_err_count;
  assign err_addr      = r_err_addr;
  assign err_write     = r_err_write;

endmodule

// File: tb/tb_ahb_err_subordinate.sv
// Bench for ahb_err_subordinate: three parameterisations share one stimulus
// stream and are checked every cycle against a response-timeline model.
module tb_ahb_err_subordinate;

  localparam int NDUT = 3;
  localparam int WS   [NDUT] = '{0, 3, 2};
  localparam int RM   [NDUT] = '{0, 0, 1};
  localparam int CW   [NDUT] = '{8, 4, 8};
  localparam int CMAX [NDUT] = '{255, 15, 255};

  logic        clk;
  logic        rst_n;
  logic        s_sel;
  logic [1:0]  s_trans;
  logic        s_write;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_clr;
  logic        s_gate;
  logic        chk_en;

  int n_vec;
  int n_bad;

  logic        d_rdy   [NDUT];
  logic [1:0]  d_resp  [NDUT];
  logic [31:0] d_rdata [NDUT];
  int          d_cnt   [NDUT];
  logic [31:0] d_addr  [NDUT];
  logic        d_write [NDUT];

  int          m_since [NDUT];
  int          m_cnt   [NDUT];
  logic [31:0] m_addr  [NDUT];
  logic        m_write [NDUT];
  logic [2:0]  m_out   [NDUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_err_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [CW[g]-1:0] w_cnt;
    logic [31:0]      w_addr;
    logic             w_write;

    assign bus_if[g].HSEL   = s_sel;
    assign bus_if[g].HADDR  = s_addr;
    assign bus_if[g].HTRANS = s_trans;
    assign bus_if[g].HWRITE = s_write;
    assign bus_if[g].HSIZE  = 3'b010;
    assign bus_if[g].HBURST = 3'b000;
    assign bus_if[g].HWDATA = s_wdata;
    assign bus_if[g].HREADY = m_out[g][2] & s_gate;

    ahb_err_subordinate #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .WAIT_STATES(WS[g]),
      .RESP_MODE  (RM[g]),
      .CNT_WIDTH  (CW[g])
    ) u_dut (
      .HCLK     (clk),
      .HRESETn  (rst_n),
      .bus      (bus_if[g]),
      .err_clr  (s_clr),
      .err_count(w_cnt),
      .err_addr (w_addr),
      .err_write(w_write)
    );

    assign d_rdy[g]   = bus_if[g].HREADYOUT;
    assign d_resp[g]  = bus_if[g].HRESP;
    assign d_rdata[g] = bus_if[g].HRDATA;
    assign d_cnt[g]   = 32'(w_cnt);
    assign d_addr[g]  = w_addr;
    assign d_write[g] = w_write;
  end

  // Expected {HREADYOUT, HRESP} given cycles elapsed since the last accept.
  function automatic logic [2:0] exp_out(input int since, input int ws, input int rm);
    if (since >= 1 && since <= ws) return 3'b0_00;
    if (since == ws + 1)           return (rm != 0) ? 3'b1_00 : 3'b0_01;
    if (since == ws + 2 && rm == 0) return 3'b1_01;
    return 3'b1_00;
  endfunction

  always_comb begin
    for (int i = 0; i < NDUT; i++) m_out[i] = exp_out(m_since[i], WS[i], RM[i]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        m_since[i] <= 0;
        m_cnt[i]   <= 0;
        m_addr[i]  <= '0;
        m_write[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        if (s_sel && s_trans[1] && m_out[i][2] && s_gate) begin
          m_since[i] <= 1;
          m_cnt[i]   <= s_clr ? 1 : ((m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : m_cnt[i]);
          m_addr[i]  <= s_addr;
          m_write[i] <= s_write;
        end else begin
          if (m_since[i] != 0 && m_since[i] < 100) m_since[i] <= m_since[i] + 1;
          if (s_clr) begin
            m_cnt[i]   <= 0;
            m_addr[i]  <= '0;
            m_write[i] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NDUT; i++) begin
        cmp($sformatf("dut%0d HREADYOUT", i), 64'(d_rdy[i]),   64'(m_out[i][2]));
        cmp($sformatf("dut%0d HRESP", i),     64'(d_resp[i]),  64'(m_out[i][1:0]));
        cmp($sformatf("dut%0d HRDATA", i),    64'(d_rdata[i]), 64'd0);
        cmp($sformatf("dut%0d err_count", i), 64'(d_cnt[i]),   64'(m_cnt[i]));
        cmp($sformatf("dut%0d err_addr", i),  64'(d_addr[i]),  64'(m_addr[i]));
        cmp($sformatf("dut%0d err_write", i), 64'(d_write[i]), 64'(m_write[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_sel   = 1'b0;
    s_trans = 2'b00;
    s_clr   = 1'b0;
    repeat (n) step();
  endtask

  task automatic xfer(input logic [1:0] tr, input logic wr, input logic [31:0] a);
    s_sel   = 1'b1;
    s_trans = tr;
    s_write = wr;
    s_addr  = a;
    s_wdata = a ^ 32'hA5A5_5A5A;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; chk_en = 1'b0;
    rst_n = 1'b0; s_sel = 1'b0; s_trans = 2'b00; s_write = 1'b0;
    s_addr = '0; s_wdata = '0; s_clr = 1'b0; s_gate = 1'b1;

    repeat (3) step();
    for (int i = 0; i < NDUT; i++) begin
      cmp($sformatf("reset dut%0d HREADYOUT", i), 64'(d_rdy[i]), 64'd1);
      cmp($sformatf("reset dut%0d HRESP", i),     64'(d_resp[i]), 64'd0);
      cmp($sformatf("reset dut%0d err_count", i), 64'(d_cnt[i]), 64'd0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    // single NONSEQ write, zero wait states
    xfer(2'b10, 1'b1, 32'h0000_1000);
    step();
    cmp("wr ERR1 HREADYOUT", 64'(d_rdy[0]), 64'd0);
    cmp("wr ERR1 HRESP", 64'(d_resp[0]), 64'd1);
    cmp("wr err_count", 64'(d_cnt[0]), 64'd1);
    cmp("wr err_addr", 64'(d_addr[0]), 64'h1000);
    cmp("wr err_write", 64'(d_write[0]), 64'd1);
    idle(1);
    cmp("wr ERR2 HREADYOUT", 64'(d_rdy[0]), 64'd1);
    cmp("wr ERR2 HRESP", 64'(d_resp[0]), 64'd1);
    idle(1);
    cmp("wr idle HRESP", 64'(d_resp[0]), 64'd0);
    idle(4);

    // read with wait states (dut1: 3 waits ERROR, dut2: 2 waits OKAY)
    xfer(2'b10, 1'b0, 32'h0000_2000);
    step();
    cmp("rd w1 dut1 HREADYOUT", 64'(d_rdy[1]), 64'd0);
    cmp("rd w1 dut1 HRESP", 64'(d_resp[1]), 64'd0);
    cmp("rd w1 dut2 HREADYOUT", 64'(d_rdy[2]), 64'd0);
    idle(1);
    cmp("rd w2 dut1 HREADYOUT", 64'(d_rdy[1]), 64'd0);
    cmp("rd w2 dut2 HREADYOUT", 64'(d_rdy[2]), 64'd0);
    idle(1);
    cmp("rd w3 dut1 HREADYOUT", 64'(d_rdy[1]), 64'd0);
    cmp("rd w3 dut1 HRESP", 64'(d_resp[1]), 64'd0);
    cmp("rd done dut2 HREADYOUT", 64'(d_rdy[2]), 64'd1);
    cmp("rd done dut2 HRESP", 64'(d_resp[2]), 64'd0);
    cmp("rd done dut2 HRDATA", 64'(d_rdata[2]), 64'd0);
    cmp("rd dut2 err_count", 64'(d_cnt[2]), 64'd2);
    idle(1);
    cmp("rd ERR1 dut1 HREADYOUT", 64'(d_rdy[1]), 64'd0);
    cmp("rd ERR1 dut1 HRESP", 64'(d_resp[1]), 64'd1);
    idle(1);
    cmp("rd ERR2 dut1 HREADYOUT", 64'(d_rdy[1]), 64'd1);
    cmp("rd ERR2 dut1 HRESP", 64'(d_resp[1]), 64'd1);
    cmp("rd dut1 err_write", 64'(d_write[1]), 64'd0);
    cmp("rd dut1 err_addr", 64'(d_addr[1]), 64'h2000);
    idle(3);

    // IDLE/BUSY selected, NONSEQ unselected, NONSEQ with HREADY low: no accepts
    xfer(2'b00, 1'b1, 32'h0000_6000); step();
    xfer(2'b01, 1'b1, 32'h0000_6004); step();
    xfer(2'b10, 1'b1, 32'h0000_6008); s_sel = 1'b0; step();
    xfer(2'b10, 1'b1, 32'h0000_600C); s_gate = 1'b0; step();
    s_sel = 1'b0; s_trans = 2'b00; s_gate = 1'b1;
    idle(1);
    cmp("noacc err_count", 64'(d_cnt[0]), 64'd2);
    cmp("noacc err_addr", 64'(d_addr[0]), 64'h2000);

    // back-to-back NONSEQ/SEQ stream
    for (int k = 0; k < 8; k++) begin
      xfer((k == 0) ? 2'b10 : 2'b11, 1'(k & 1), 32'h0000_3000 + 32'(4 * k));
      step();
      if (k == 2) begin
        cmp("b2b ERR1 HREADYOUT", 64'(d_rdy[0]), 64'd0);
        cmp("b2b ERR1 HRESP", 64'(d_resp[0]), 64'd1);
      end
    end
    idle(6);
    cmp("b2b err_count", 64'(d_cnt[0]), 64'd6);
    cmp("b2b err_addr", 64'(d_addr[0]), 64'h3018);

    // saturation of the 4-bit counter
    xfer(2'b10, 1'b1, 32'h0000_4000);
    repeat (90) step();
    idle(6);
    cmp("sat dut1 err_count", 64'(d_cnt[1]), 64'd15);

    // clear together with an accept, then clear alone
    xfer(2'b10, 1'b0, 32'h0000_5000);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    cmp("clr+acc dut1 err_count", 64'(d_cnt[1]), 64'd1);
    cmp("clr+acc dut1 err_addr", 64'(d_addr[1]), 64'h5000);
    cmp("clr+acc dut0 err_count", 64'(d_cnt[0]), 64'd1);
    idle(6);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    cmp("clr dut1 err_count", 64'(d_cnt[1]), 64'd0);
    cmp("clr dut0 err_addr", 64'(d_addr[0]), 64'h0);
    idle(2);

    // reset asserted during ERR1 aborts the response
    xfer(2'b10, 1'b1, 32'h0000_7000);
    step();
    s_sel = 1'b0; s_trans = 2'b00;
    cmp("pre-rst ERR1 HREADYOUT", 64'(d_rdy[0]), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    cmp("rst async HREADYOUT", 64'(d_rdy[0]), 64'd1);
    cmp("rst async HRESP", 64'(d_resp[0]), 64'd0);
    cmp("rst async err_count", 64'(d_cnt[0]), 64'd0);
    #1 rst_n = 1'b1;
    step();
    cmp("post-rst no ERR2 HRESP", 64'(d_resp[0]), 64'd0);
    cmp("post-rst HREADYOUT", 64'(d_rdy[0]), 64'd1);
    idle(4);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
